bcd_div_seq: RTL and testbench
==============================

BCD_DIV_SEQ -- requirements
Module: bcd_div_seq

Interface
REQ-001 The block SHALL expose a parameter NDIG, default 4, giving the number of BCD digits per operand (legal 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a new operand.
REQ-005 The block SHALL have port digit_in, input, 4 bits, one BCD digit, most significant digit first.
REQ-006 The block SHALL have port digit_valid, input, 1 bit, meaning digit_in holds a digit.
REQ-007 The block SHALL have port digit_ready, output, 1 bit, meaning the block accepts a digit this cycle.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operand is being loaded.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when a result is available.
REQ-010 The block SHALL have ports out3 and out11, outputs, 1 bit each, set when the operand is divisible by 3 or by 11 respectively.
REQ-011 The block SHALL have port bcd_err, output, 1 bit, set when any digit of the operand exceeded 9.

Function
REQ-012 The FSM SHALL have three states: IDLE, LOAD and RESULT.
- IDLE -> LOAD on start.
- LOAD -> RESULT on acceptance of digit NDIG.
- RESULT -> IDLE after one cycle.
REQ-013 A digit SHALL be accepted only in a cycle where digit_valid and digit_ready are both 1; digit_ready SHALL equal 1 exactly in LOAD.
REQ-014 On start in IDLE, the block SHALL clear r3, r11, the digit counter and bcd_err, and SHALL clear out3 and out11.
REQ-015 Per accepted digit d, the block SHALL update r3 <= (r3 + d) mod 3 and r11 <= (d - r11) mod 11 (equivalent to (10*r11 + d) mod 11); all intermediates SHALL be wide enough that no overflow occurs.
REQ-016 The digit counter SHALL count accepted digits 0..NDIG-1 only and SHALL never wrap inside an operand.
REQ-017 Digits with value 10..15 SHALL still be consumed and counted, SHALL set bcd_err sticky for the operand, and SHALL leave r3 and r11 unchanged.
REQ-018 done SHALL pulse in the cycle after the last digit is accepted (RESULT state), and out3, out11 and bcd_err SHALL become valid in that same cycle.
REQ-019 out3 SHALL equal (r3 == 0) and not bcd_err; out11 SHALL equal (r11 == 0) and not bcd_err.
REQ-020 out3, out11 and bcd_err SHALL hold their values until the next accepted start.
REQ-021 A start asserted in LOAD SHALL be ignored, and the operand in progress SHALL continue.
REQ-022 A start asserted in RESULT SHALL be ignored; start is sampled again in IDLE on the following cycle.
REQ-023 busy SHALL equal 1 exactly in LOAD.
REQ-024 Stalls (digit_valid low) SHALL leave all state unchanged, with no timeout.

Reset
REQ-025 When rst_n is low, the block SHALL immediately force state to IDLE, clear the counter, r3 and r11, and drive digit_ready, busy, done, out3, out11 and bcd_err to 0.
REQ-026 A reset during LOAD SHALL discard the partial operand and SHALL produce no done pulse.
REQ-027 After rst_n is released, the first start SHALL be honoured on the first rising edge.

Structure
REQ-028 A shared package bcd_pkg SHALL hold the state enum, the constants MOD3 = 3, MOD11 = 11 and BCD_MAX = 9, and the digit width of 4.
REQ-029 A combinational sub-module bcd_mod_step SHALL compute the next r3, the next r11 and the invalid-digit flag from the current remainders and d; the top level SHALL contain only the FSM, the counter and the output registers.

Verification
REQ-030 The bench SHALL cover: start, then digits 1,3,4,6 -> done pulses one cycle after the 6 is accepted, out3 = 0, out11 = 0, bcd_err = 0.
REQ-031 The bench SHALL cover: digits 9,2,7,3 -> out3 = 1, out11 = 1; then a new operand 9,2,7,6 -> out3 = 1, out11 = 0, with the previous results held until that start.
REQ-032 The bench SHALL cover: digits 0,0,0,0 -> out3 = 1, out11 = 1; digits 1,2,10,1 -> bcd_err = 1, out3 = 0, out11 = 0.
REQ-033 The bench SHALL cover: digit_valid low for 5 cycles between digits 2 and 3 of 9273 -> result still out3 = 1, out11 = 1, with busy high throughout.
REQ-034 The bench SHALL cover: rst_n pulsed low after two digits -> all outputs 0 asynchronously, no done; a following start with 1,3,4,6 -> correct result.
REQ-035 The bench SHALL cover: start pulsed during LOAD and during RESULT -> ignored, and the digit count and results are unaffected.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD divisibility checker
package bcd_pkg;

    localparam int DIG_W   = 4;
    localparam int MOD3    = 3;
    localparam int MOD11   = 11;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_mod_step.sv
// rtl/bcd_mod_step.sv - one-digit update of the mod-3 and mod-11 remainders
module bcd_mod_step
    import bcd_pkg::*;
(
    input  logic [1:0]       r3,
    input  logic [3:0]       r11,
    input  logic [DIG_W-1:0] d,
    output logic [1:0]       r3_next,
    output logic [3:0]       r11_next,
    output logic             invalid
);

    // 5-bit intermediates: r3 + d <= 17 and d + 11 - r11 <= 26, so nothing wraps.
    logic [4:0] sum3;
    logic [4:0] sum11;
    logic [4:0] mod3_v;
    logic [4:0] mod11_v;

    // Remainder update; 10 == -1 (mod 11) turns (10*r + d) into (d - r), biased by 11 to stay positive.
    always_comb begin
        sum3     = 5'(r3) + 5'(d);
        sum11    = 5'(d) + 5'(MOD11) - 5'(r11);
        mod3_v   = sum3 % 5'(MOD3);
        mod11_v  = sum11 % 5'(MOD11);
        invalid  = (d > 4'(BCD_MAX));
        r3_next  = r3;
        r11_next = r11;
        if (!invalid) begin
            r3_next  = mod3_v[1:0];
            r11_next = mod11_v[3:0];
        end
    end

endmodule

// File: rtl/bcd_div_seq.sv
// rtl/bcd_div_seq.sv - serial BCD operand loader reporting divisibility by 3 and 11
module bcd_div_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIG_W-1:0] digit_in,
    input  logic             digit_valid,
    output logic             digit_ready,
    output logic             busy,
    output logic             done,
    output logic             out3,
    output logic             out11,
    output logic             bcd_err
);

    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       r3;
    logic [3:0]       r11;
    logic             err_acc;

    logic             accept;
    logic             last_digit;
    logic             start_ok;
    logic [1:0]       r3_n;
    logic [3:0]       r11_n;
    logic             invalid;
    logic             err_final;

    assign digit_ready = (state == ST_LOAD);
    assign busy        = (state == ST_LOAD);
    assign done        = (state == ST_RESULT);
    assign accept      = digit_valid && (state == ST_LOAD);
    assign last_digit  = accept && (cnt == LAST_IDX);
    assign start_ok    = start && (state == ST_IDLE);
    assign err_final   = err_acc | invalid;

    bcd_mod_step u_step (
        .r3       (r3),
        .r11      (r11),
        .d        (digit_in),
        .r3_next  (r3_n),
        .r11_next (r11_n),
        .invalid  (invalid)
    );

    // Control FSM: start is only honoured in IDLE, RESULT lasts exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   if (start) state <= ST_LOAD;
                ST_LOAD:   if (last_digit) state <= ST_RESULT;
                ST_RESULT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Digit counter and running remainders; the counter holds at the last index instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            r3      <= '0;
            r11     <= '0;
            err_acc <= 1'b0;
        end else if (start_ok) begin
            cnt     <= '0;
            r3      <= '0;
            r11     <= '0;
            err_acc <= 1'b0;
        end else if (accept) begin
            r3      <= r3_n;
            r11     <= r11_n;
            err_acc <= err_final;
            if (!last_digit) cnt <= cnt + CNT_W'(1);
        end
    end

    // Result registers: captured with the last digit so they are valid during RESULT and held after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out3    <= 1'b0;
            out11   <= 1'b0;
            bcd_err <= 1'b0;
        end else if (start_ok) begin
            out3    <= 1'b0;
            out11   <= 1'b0;
            bcd_err <= 1'b0;
        end else if (last_digit) begin
            bcd_err <= err_final;
            out3    <= (r3_n == 2'd0) && !err_final;
            out11   <= (r11_n == 4'd0) && !err_final;
        end
    end

endmodule

// File: tb/tb_bcd_div_seq.sv
// tb/tb_bcd_div_seq.sv - self-checking bench for bcd_div_seq
module tb_bcd_div_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       busy;
    logic       done;
    logic       out3;
    logic       out11;
    logic       bcd_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit prev3 = 1'b0;
    bit prev11 = 1'b0;
    bit preverr = 1'b0;

    always #5 clk = ~clk;

    bcd_div_seq #(.NDIG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .busy        (busy),
        .done        (done),
        .out3        (out3),
        .out11       (out11),
        .bcd_err     (bcd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the operand as an integer, divisibility by plain arithmetic.
    function automatic void model(input logic [15:0] w, output bit e3, output bit e11, output bit eerr);
        int v;
        int dd;
        v    = 0;
        eerr = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            dd = int'(w[i*4 +: 4]);
            if (dd > 9) eerr = 1'b1;
            else v = v * 10 + dd;
        end
        e3  = !eerr && (v % 3 == 0);
        e11 = !eerr && (v % 11 == 0);
    endfunction

    task automatic run_op(input logic [15:0] w, input int stall_at, input int stall_len,
                          input bit start_in_load, input bit start_in_result);
        bit e3, e11, ee;
        model(w, e3, e11, ee);
        @(negedge clk);
        chk("hold_out3", out3, prev3);
        chk("hold_out11", out11, prev11);
        chk("hold_err", bcd_err, preverr);
        chk("idle_ready", digit_ready, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("clr_out3", out3, 0);
        chk("clr_out11", out11, 0);
        chk("clr_err", bcd_err, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                digit_valid = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk("stall_busy", busy, 1);
                    chk("stall_done", done, 0);
                end
            end
            digit_in    = w[(3-i)*4 +: 4];
            digit_valid = 1'b1;
            if (start_in_load && i == 1) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (i < 3) begin
                chk("load_done_low", done, 0);
                chk("load_busy", busy, 1);
            end
        end
        digit_valid = 1'b0;
        chk("done_pulse", done, 1);
        chk("res_out3", out3, e3);
        chk("res_out11", out11, e11);
        chk("res_err", bcd_err, ee);
        chk("res_busy", busy, 0);
        if (start_in_result) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_after_result", busy, 0);
        chk("held_out3", out3, e3);
        chk("held_out11", out11, e11);
        chk("held_err", bcd_err, ee);
        prev3   = e3;
        prev11  = e11;
        preverr = ee;
    endtask

    initial begin
        logic [15:0] w;
        int v;
        rst_n       = 1'b0;
        start       = 1'b0;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", digit_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out3", out3, 0);
        chk("rst_out11", out11, 0);
        chk("rst_err", bcd_err, 0);
        rst_n = 1'b1;

        run_op(16'h1346, -1, 0, 1'b0, 1'b0);
        run_op(16'h9273, -1, 0, 1'b0, 1'b0);
        run_op(16'h9276, -1, 0, 1'b0, 1'b0);
        run_op(16'h0000, -1, 0, 1'b0, 1'b0);
        run_op(16'h12A1, -1, 0, 1'b0, 1'b0);
        run_op(16'h9273, 2, 5, 1'b0, 1'b0);
        run_op(16'h9273, -1, 0, 1'b1, 1'b1);

        // Reset in the middle of an operand.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        digit_valid = 1'b1;
        digit_in    = 4'd1;
        @(negedge clk);
        digit_in = 4'd3;
        @(negedge clk);
        digit_in = 4'd4;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", digit_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_out3", out3, 0);
        chk("arst_out11", out11, 0);
        chk("arst_err", bcd_err, 0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
        end
        digit_valid = 1'b0;
        rst_n       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        prev3   = 1'b0;
        prev11  = 1'b0;
        preverr = 1'b0;
        run_op(16'h1346, -1, 0, 1'b0, 1'b0);

        // Async reset while results are high.
        run_op(16'h0000, -1, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi_out3", out3, 0);
        chk("arst_hi_out11", out11, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev3   = 1'b0;
        prev11  = 1'b0;
        preverr = 1'b0;

        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) begin
                v = 33 * $urandom_range(0, 302);
                w = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            end else begin
                for (int j = 0; j < 4; j++)
                    w[j*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
            end
            run_op(w, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
                   int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
